gpi_debounce: RTL and testbench

Input-conditioning stage between the board switch pads (user DIP switches, navigation joystick) and the system's general-purpose input bus.
- Synchronises each asynchronous, already-inverted switch level into clk_sys.
- Debounces each bit with a shared millisecond-scale prescaler and a per-bit stability counter.
- Presents clean levels plus single-cycle rise/fall event pulses to sonata_system gp_i and interrupt logic.

---
 rtl/gpi_debounce_pkg.sv | 17 +
 rtl/gpi_debounce_bit.sv | 91 +++++++++
 rtl/gpi_debounce.sv | 71 +++++++
 tb/tb_gpi_debounce.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_debounce_pkg.sv
// Shared definitions for the general-purpose input debouncer.
// Holds the default sizing constants and the counter-width helper used by
// gpi_debounce and gpi_debounce_bit.
package gpi_debounce_pkg;

  localparam int GpiDefaultWidth         = 13;
  localparam int GpiDefaultTickDiv       = 50000;
  localparam int GpiDefaultDebounceTicks = 5;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One debounce channel: synchroniser chain, stability counter, debounced
// level with registered rise/fall pulses.
// With GPI_EVENT_LATCH_EN defined, a sticky event flag with a per-channel
// clear is added; set takes priority over clear.
module gpi_debounce_bit
  import gpi_debounce_pkg::*;
#(
  parameter int   SyncStages    = 2,
  parameter int   DebounceTicks = GpiDefaultDebounceTicks,
  parameter logic ResetValue    = 1'b0
) (
  input  logic clk_sys,
  input  logic rst_sys_n,
  input  logic tick,
  input  logic gpi_i,
  output logic gpi_o,
  output logic rise_o,
  output logic fall_o
`ifdef GPI_EVENT_LATCH_EN
  ,
  input  logic evt_clr_i,
  output logic evt_o
`endif
);

  localparam int              CntW    = cnt_width(DebounceTicks + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

  logic [SyncStages-1:0] sync_chain;
  logic                  sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  gpi_q;
  logic                  rise_q;
  logic                  fall_q;

  // Metastability chain: the pad level reaches sync_q after SyncStages edges.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      sync_chain <= {SyncStages{ResetValue}};
    end else begin
      sync_chain <= {sync_chain[SyncStages-2:0], gpi_i};
    end
  end

  assign sync_q = sync_chain[SyncStages-1];

  // Count ticks of continuous disagreement; flip the output on the last one.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cnt_q  <= '0;
      gpi_q  <= ResetValue;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync_q == gpi_q) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == CntLast) begin
          gpi_q  <= sync_q;
          cnt_q  <= '0;
          rise_q <= sync_q;
          fall_q <= ~sync_q;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign gpi_o  = gpi_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef GPI_EVENT_LATCH_EN
  logic evt_q;

  // Sticky event flag; a new edge in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= (evt_q & ~evt_clr_i) | rise_q | fall_q;
    end
  end

  assign evt_o = evt_q;
`endif

endmodule

// File: rtl/gpi_debounce.sv
// Switch-input conditioning: per-bit synchronise + debounce with a shared
// prescaler producing the debounce tick.
// Optional feature macro: GPI_EVENT_LATCH_EN adds evt_clr_i / evt_o sticky
// event flags per channel.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int               Width         = GpiDefaultWidth,
  parameter int               SyncStages    = 2,
  parameter int               TickDiv       = GpiDefaultTickDiv,
  parameter int               DebounceTicks = GpiDefaultDebounceTicks,
  parameter logic [Width-1:0] ResetValue    = '0
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic [Width-1:0] gpi_i,
  output logic [Width-1:0] gpi_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             tick_o
`ifdef GPI_EVENT_LATCH_EN
  ,
  input  logic [Width-1:0] evt_clr_i,
  output logic [Width-1:0] evt_o
`endif
);

  localparam int              PreW    = cnt_width(TickDiv);
  localparam logic [PreW-1:0] PreLast = PreW'(TickDiv - 1);

  logic [PreW-1:0] pre_q;
  logic            tick;
  logic            tick_q;

  assign tick = (pre_q == PreLast);

  // Free-running prescaler shared by every channel; tick_o lags tick by one cycle.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
      pre_q  <= tick ? '0 : pre_q + PreW'(1);
    end
  end

  assign tick_o = tick_q;

  for (genvar gi = 0; gi < Width; gi++) begin : g_chan
    gpi_debounce_bit #(
      .SyncStages    (SyncStages),
      .DebounceTicks (DebounceTicks),
      .ResetValue    (ResetValue[gi])
    ) u_bit (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .tick      (tick),
      .gpi_i     (gpi_i[gi]),
      .gpi_o     (gpi_o[gi]),
      .rise_o    (rise_o[gi]),
      .fall_o    (fall_o[gi])
`ifdef GPI_EVENT_LATCH_EN
      ,
      .evt_clr_i (evt_clr_i[gi]),
      .evt_o     (evt_o[gi])
`endif
    );
  end

endmodule

// File: tb/tb_gpi_debounce.sv
// Scoreboard bench for gpi_debounce (TickDiv=4, DebounceTicks=3).
// Stimulus pushes the expected edge event (rise/fall/level and exact cycle);
// a negedge monitor pops and compares whenever a pulse appears, and checks
// tick_o, reset state and level stability on every other cycle.
module tb_gpi_debounce;

  localparam int W  = 13;
  localparam int SS = 2;
  localparam int TD = 4;
  localparam int DT = 3;

  logic         clk_sys   = 1'b0;
  logic         rst_sys_n = 1'b0;
  logic [W-1:0] gpi_i     = '0;
  logic [W-1:0] gpi_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         tick_o;
`ifdef GPI_EVENT_LATCH_EN
  logic [W-1:0] evt_clr_i = '0;
  logic [W-1:0] evt_o;
`endif

  gpi_debounce #(
    .Width         (W),
    .SyncStages    (SS),
    .TickDiv       (TD),
    .DebounceTicks (DT),
    .ResetValue    ('0)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .gpi_i     (gpi_i),
    .gpi_o     (gpi_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .tick_o    (tick_o)
`ifdef GPI_EVENT_LATCH_EN
    ,
    .evt_clr_i (evt_clr_i),
    .evt_o     (evt_o)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] gpi;
    int           at;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] exp_gpi = '0;
  logic [W-1:0] mon_gpi = '0;
  int           cyc     = 0;
  int           rel_cyc = 0;
  int           mon_k   = 0;
  int           checks  = 0;
  int           errors  = 0;

  always @(posedge clk_sys) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset state, tick cadence, scoreboard pops on pulses, level hold otherwise.
  always @(negedge clk_sys) begin
    if (!rst_sys_n) begin
      chk("reset_gpi", 32'(gpi_o), 32'(0));
      chk("reset_pulses", 32'({rise_o, fall_o}), 32'(0));
      chk("reset_tick", 32'(tick_o), 32'(0));
      mon_gpi = '0;
    end else begin
      mon_k = cyc - rel_cyc;
      chk("tick", 32'(tick_o), 32'((mon_k > 0) && (mon_k % TD == 0)));
      if ((rise_o | fall_o) != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: rise %0h fall %0h, expected none (cycle %0d)",
                   rise_o, fall_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_rise", 32'(rise_o), 32'(mon_e.rise));
          chk("evt_fall", 32'(fall_o), 32'(mon_e.fall));
          chk("evt_gpi", 32'(gpi_o), 32'(mon_e.gpi));
          chk("evt_cycle", 32'(cyc), 32'(mon_e.at));
          mon_gpi = mon_e.gpi;
        end
      end else begin
        chk("gpi_hold", 32'(gpi_o), 32'(mon_gpi));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Cycle in which gpi_o shows a pin change driven during cycle c.
  function automatic int flip_cycle(input int c);
    int t;
    t = c + SS;
    while (((t - rel_cyc) % TD) != TD - 1) t++;
    return t + TD * (DT - 1) + 1;
  endfunction

  task automatic drive(input logic [W-1:0] v);
    exp_t e;
    e.rise = v & ~exp_gpi;
    e.fall = ~v & exp_gpi;
    e.gpi  = v;
    e.at   = flip_cycle(cyc);
    if (v != exp_gpi) exp_q.push_back(e);
    exp_gpi = v;
    gpi_i   = v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events pending, expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset and idle
    step(3);
    rst_sys_n = 1'b1;
    rel_cyc   = cyc;
    step(100);
    chk("idle_gpi", 32'(gpi_o), 32'(0));

    // Clean press and release on bit 0
    drive(13'h0001);
    drain(30);
    step(3);
    chk("press_gpi", 32'(gpi_o), 32'(1));
    drive(13'h0000);
    drain(30);

    // Bounce on bit 3: never stable long enough to flip
    for (int r = 0; r < 5; r++) begin
      gpi_i[3] = 1'b1;
      step(6);
      gpi_i[3] = 1'b0;
      step(2);
    end
    step(30);
    chk("bounce_gpi", 32'(gpi_o), 32'(0));

    // All bits at once
    drive(13'h1FFF);
    drain(30);
    drive(13'h0000);
    drain(30);

    // Reset part-way through a debounce
    gpi_i = 13'h0001;
    step(4);
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    chk("rst_mid_gpi", 32'(gpi_o), 32'(0));
    step(2);
    rst_sys_n = 1'b1;
    rel_cyc   = cyc;
    drive(13'h0001);
    drain(30);
    chk("rst_mid_after", 32'(gpi_o), 32'(1));

`ifdef GPI_EVENT_LATCH_EN
    begin
      int fcyc;
      drive(13'h0021);
      drain(30);
      chk("evt_set", 32'(evt_o[5]), 32'(1));
      for (int i = 0; i < 5; i++) begin
        step(10);
        chk("evt_hold", 32'(evt_o[5]), 32'(1));
      end
      drive(13'h0001);
      fcyc = exp_q[$].at;
      while (cyc < fcyc) step(1);
      evt_clr_i[5] = 1'b1;
      step(1);
      evt_clr_i[5] = 1'b0;
      drain(30);
      chk("evt_set_wins", 32'(evt_o[5]), 32'(1));
      step(5);
      evt_clr_i[5] = 1'b1;
      step(1);
      evt_clr_i[5] = 1'b0;
      chk("evt_cleared", 32'(evt_o[5]), 32'(0));
      chk("evt_other", 32'(evt_o[0]), 32'(1));
    end
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
